// File: rtl/dmem_bus_if.sv
// Wait-state data bus between dmem_bridge (master) and the data memory (slave).
interface dmem_bus_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_o;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, bus_err_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, bus_err_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/dmem_bridge.sv
// Bridges the memory-access stage onto a req/ack wait-state bus, stalling the
// pipeline until each access completes or times out.
module dmem_bridge #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_data_i,
  input  logic              flush_i,
  output logic [31:0]       mem_data_o,
  output logic              stallreq_o,
  dmem_bus_if.master        bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rbuf_q, rbuf_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       sel_q, sel_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic             aborted_q, aborted_d;
  logic             accept_c;
  logic             unused_addr_lsb;

  assign accept_c        = mem_ce_i & ~flush_i;
  assign unused_addr_lsb = ^mem_addr_i[1:0];

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rbuf_d    = rbuf_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    req_d     = req_q;
    we_d      = we_q;
    err_d     = 1'b0;
    aborted_d = aborted_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          we_d    = mem_we_i;
          addr_d  = {mem_addr_i[31:2], 2'b00};
          sel_d   = mem_sel_i;
          wdata_d = mem_data_i;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (flush_i) aborted_d = 1'b1;
        // Ack takes priority over a coincident timeout.
        if (bus.bus_ack_i) begin
          rbuf_d  = bus.bus_rdata_i;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rbuf_d  = '0;
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        aborted_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rbuf_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rbuf_q    <= rbuf_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      req_q     <= req_d;
      we_q      <= we_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.bus_req_o   = req_q;
  assign bus.bus_we_o    = we_q;
  assign bus.bus_addr_o  = addr_q;
  assign bus.bus_sel_o   = sel_q;
  assign bus.bus_wdata_o = wdata_q;
  assign bus.bus_err_o   = err_q;

  // Stall is released for exactly the one non-aborted DONE cycle.
  assign stallreq_o = ((state_q == IDLE) && accept_c) || (state_q == BUSY) ||
                      ((state_q == DONE) && aborted_q);
  assign mem_data_o = ((state_q == DONE) && !aborted_q) ? rbuf_q : 32'h0;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed per-cycle vector table plus hand-written reset/back-to-back sequences.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ce_i, mem_we_i, flush_i;
  logic [31:0] mem_addr_i, mem_data_i, mem_data_o;
  logic [3:0]  mem_sel_i;
  logic        stallreq_o;
  int          tests = 0;
  int          fails = 0;

  dmem_bus_if bus ();

  dmem_bridge #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_ce_i   (mem_ce_i),
    .mem_we_i   (mem_we_i),
    .mem_addr_i (mem_addr_i),
    .mem_sel_i  (mem_sel_i),
    .mem_data_i (mem_data_i),
    .flush_i    (flush_i),
    .mem_data_o (mem_data_o),
    .stallreq_o (stallreq_o),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Expected-output packing: {stall, req, we, addr, sel, wdata, err, mdata}
  typedef struct {
    logic         ce, we;
    logic [31:0]  addr;
    logic [3:0]   sel;
    logic [31:0]  wd;
    logic         flush, ack;
    logic [31:0]  rd;
    logic [103:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [103:0] ex(input logic st, rq, w, input logic [31:0] a,
                                      input logic [3:0] s, input logic [31:0] wd,
                                      input logic er, input logic [31:0] md);
    return {st, rq, w, a, s, wd, er, md};
  endfunction

  function automatic logic [103:0] outs();
    return {stallreq_o, bus.bus_req_o, bus.bus_we_o, bus.bus_addr_o, bus.bus_sel_o,
            bus.bus_wdata_o, bus.bus_err_o, mem_data_o};
  endfunction

  task automatic add(input logic ce, we, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] wd, input logic fl, ack, input logic [31:0] rd,
                     input logic [103:0] e);
    vec_t v;
    v.ce = ce; v.we = we; v.addr = a; v.sel = s; v.wd = wd;
    v.flush = fl; v.ack = ack; v.rd = rd; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ce, we, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] wd, input logic fl, ack, input logic [31:0] rd);
    mem_ce_i = ce; mem_we_i = we; mem_addr_i = a; mem_sel_i = s; mem_data_i = wd;
    flush_i = fl; bus.bus_ack_i = ack; bus.bus_rdata_i = rd;
  endtask

  task automatic chk(input string name, input logic [103:0] got, input logic [103:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // One read: IDLE request cycle, `waits` BUSY cycles, ack cycle, DONE cycle.
  task automatic rd_seq(input logic [31:0] a, input logic [31:0] d, input int waits);
    @(negedge clk); drive(1, 0, a, 4'hF, 0, 0, 0, 0); #1;
    chk("b2b_idle_req", {103'h0, bus.bus_req_o}, 104'h0);
    chk("b2b_idle_stall", {103'h0, stallreq_o}, 104'h1);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk); drive(1, 0, a, 4'hF, 0, 0, 0, 0); #1;
      chk("b2b_busy_req", {103'h0, bus.bus_req_o}, 104'h1);
    end
    @(negedge clk); drive(1, 0, a, 4'hF, 0, 0, 1, d); #1;
    chk("b2b_ack_addr", {72'h0, bus.bus_addr_o}, {72'h0, a});
    @(negedge clk); drive(1, 0, a, 4'hF, 0, 0, 0, 0); #1;
    chk("b2b_done", outs(), ex(0, 0, 0, a, 4'hF, 0, 0, d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Read with ack on third BUSY cycle
    add(0,0,0,0,0,0,0,0,                        ex(0,0,0,0,0,0,0,0));
    add(1,0,32'h1006,4'h3,0,0,0,0,              ex(1,0,0,0,0,0,0,0));
    add(1,0,32'h1006,4'h3,0,0,0,0,              ex(1,1,0,32'h1004,4'h3,0,0,0));
    add(1,0,32'h1006,4'h3,0,0,0,0,              ex(1,1,0,32'h1004,4'h3,0,0,0));
    add(1,0,32'h1006,4'h3,0,0,1,32'hDEADBEEF,   ex(1,1,0,32'h1004,4'h3,0,0,0));
    add(1,0,32'h1006,4'h3,0,0,0,0,              ex(0,0,0,32'h1004,4'h3,0,0,32'hDEADBEEF));
    add(0,0,0,0,0,0,0,0,                        ex(0,0,0,32'h1004,4'h3,0,0,0));
    // Zero-wait write
    add(1,1,32'h20,4'hF,32'h12345678,0,0,0,     ex(1,0,0,32'h1004,4'h3,0,0,0));
    add(1,1,32'h20,4'hF,32'h12345678,0,1,32'hAAAA5555,
                                                ex(1,1,1,32'h20,4'hF,32'h12345678,0,0));
    add(0,0,0,0,0,0,0,0,                        ex(0,0,1,32'h20,4'hF,32'h12345678,0,32'hAAAA5555));
    add(0,0,0,0,0,0,0,0,                        ex(0,0,1,32'h20,4'hF,32'h12345678,0,0));
    // Timeout, no ack
    add(1,0,32'h3003,4'h8,0,0,0,0,              ex(1,0,1,32'h20,4'hF,32'h12345678,0,0));
    for (int i = 0; i < 4; i++)
      add(1,0,32'h3003,4'h8,0,0,0,0,            ex(1,1,0,32'h3000,4'h8,0,0,0));
    add(0,0,0,0,0,0,0,0,                        ex(0,0,0,32'h3000,4'h8,0,1,0));
    add(0,0,0,0,0,0,0,0,                        ex(0,0,0,32'h3000,4'h8,0,0,0));
    // Ack on the timeout cycle
    add(1,0,32'h3004,4'hF,0,0,0,0,              ex(1,0,0,32'h3000,4'h8,0,0,0));
    for (int i = 0; i < 3; i++)
      add(1,0,32'h3004,4'hF,0,0,0,0,            ex(1,1,0,32'h3004,4'hF,0,0,0));
    add(1,0,32'h3004,4'hF,0,0,1,32'hCAFEF00D,   ex(1,1,0,32'h3004,4'hF,0,0,0));
    add(0,0,0,0,0,0,0,0,                        ex(0,0,0,32'h3004,4'hF,0,0,32'hCAFEF00D));
    add(0,0,0,0,0,0,0,0,                        ex(0,0,0,32'h3004,4'hF,0,0,0));
    // Flush during a write, ack two cycles later
    add(1,1,32'h44,4'h6,32'h0BADF00D,0,0,0,     ex(1,0,0,32'h3004,4'hF,0,0,0));
    add(1,1,32'h44,4'h6,32'h0BADF00D,1,0,0,     ex(1,1,1,32'h44,4'h6,32'h0BADF00D,0,0));
    add(1,1,32'h44,4'h6,32'h0BADF00D,0,0,0,     ex(1,1,1,32'h44,4'h6,32'h0BADF00D,0,0));
    add(1,1,32'h44,4'h6,32'h0BADF00D,0,1,32'h11112222,
                                                ex(1,1,1,32'h44,4'h6,32'h0BADF00D,0,0));
    add(0,0,0,0,0,0,0,0,                        ex(1,0,1,32'h44,4'h6,32'h0BADF00D,0,0));
    // Next access shows the aborted flag was cleared
    add(1,0,32'h50,4'hF,0,0,0,0,                ex(1,0,1,32'h44,4'h6,32'h0BADF00D,0,0));
    add(1,0,32'h50,4'hF,0,0,1,32'h55AA55AA,     ex(1,1,0,32'h50,4'hF,0,0,0));
    add(0,0,0,0,0,0,0,0,                        ex(0,0,0,32'h50,4'hF,0,0,32'h55AA55AA));
    // Flush with ce in IDLE, then ack outside BUSY
    add(1,0,32'h60,4'hF,0,1,0,0,                ex(0,0,0,32'h50,4'hF,0,0,0));
    add(0,0,0,0,0,0,1,32'hFFFFFFFF,             ex(0,0,0,32'h50,4'hF,0,0,0));
    add(0,0,0,0,0,0,0,0,                        ex(0,0,0,32'h50,4'hF,0,0,0));

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].ce, vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].wd,
            vecs[i].flush, vecs[i].ack, vecs[i].rd);
      #1;
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Reset in the middle of a BUSY read
    @(negedge clk); drive(1, 0, 32'h70, 4'hF, 32'h77, 0, 0, 0); #1;
    chk("rst_pre_stall", {103'h0, stallreq_o}, 104'h1);
    @(negedge clk); #1;
    chk("rst_pre_busy", outs(), ex(1, 1, 0, 32'h70, 4'hF, 32'h77, 0, 0));
    @(negedge clk); rst = 1'b1; drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0; drive(0, 0, 0, 0, 0, 0, 1, 32'h99999999); #1;
    chk("rst_all_zero", outs(), 104'h0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("rst_stray_ack", outs(), 104'h0);

    // Back-to-back reads: DONE then IDLE keep req low between them
    rd_seq(32'h80, 32'h01020304, 1);
    rd_seq(32'h84, 32'hA5A5C3C3, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("b2b_end_idle", outs(), ex(0, 0, 0, 32'h84, 4'hF, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly downstream of the memory-access stage, between its data-RAM request signals (ce/we/addr/sel/wdata) and a wait-state data bus.
- Registers each access, drives a req/ack bus transaction, and raises a stall request to the pipeline controller until the access completes.
- Presents read data back to the memory-access stage for exactly one cycle.
- Includes a timeout counter so a missing ack cannot hang the pipeline.

Parameters:
- TIMEOUT, 16, maximum cycles in BUSY without ack before forced completion (legal range 1..255).
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- mem_ce_i  input  1  access request from memory-access stage
- mem_we_i  input  1  1=write, 0=read
- mem_addr_i  input  32  byte address
- mem_sel_i  input  4  byte enables, bit3 = bits 31:24
- mem_data_i  input  32  write data
- flush_i  input  1  pipeline flush from controller
- mem_data_o  output  32  read data returned to memory-access stage
- stallreq_o  output  1  stall request to controller
- bus_req_o  output  1  bus request, held until ack
- bus_we_o  output  1  bus write strobe
- bus_addr_o  output  32  word-aligned bus address
- bus_sel_o  output  4  bus byte enables
- bus_wdata_o  output  32  bus write data
- bus_ack_i  input  1  bus completion, single-cycle pulse
- bus_rdata_i  input  32  bus read data, valid when bus_ack_i=1
- bus_err_o  output  1  one-cycle pulse on timeout

Behaviour:
- Reset: one clock, synchronous, active-high. rst=1 at a rising edge forces state IDLE, counter 0, and read buffer 0. It also clears all bus_* registered outputs and bus_err_o to 0. Reset mid-transaction abandons it without waiting for ack; a late ack arriving after reset is ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If mem_ce_i=1 and flush_i=0, latch we, {addr[31:2],2'b00}, sel, and wdata into the bus_* registers, set bus_req_o=1, clear the counter, and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - bus_req_o and all bus_* outputs stay stable.
  - Counter increments each cycle.
  - On bus_ack_i=1: capture bus_rdata_i into the read buffer (writes capture too; the value is unused), drop bus_req_o, and go to DONE.
  - If counter reaches TIMEOUT-1 with no ack: load 0 into the buffer, drop bus_req_o, pulse bus_err_o=1 for one cycle, and go to DONE.
  - If ack and timeout occur in the same cycle, ack wins and there is no error.
- DONE: one cycle only, then IDLE unconditionally. No new request is accepted in DONE, so the stage that is now advancing cannot re-issue.
- stallreq_o (combinational): 1 when (IDLE and mem_ce_i and not flush_i), or BUSY, or (DONE and the aborted flag is set); otherwise 0. It is therefore 0 in a normal DONE cycle, which lets the pipeline advance exactly once.
- mem_data_o: equals the read buffer in DONE; 0 in all other states.
- Flush while BUSY:
  - Sets the aborted flag.
  - The bus transaction is never cut short; a write already issued completes on the bus.
  - On ack or timeout the FSM goes to DONE with mem_data_o forced to 0.
  - The aborted flag clears on entry to IDLE.
- Flush in IDLE with mem_ce_i=1: no request is issued and stallreq_o=0.
- Latency:
  - Request to bus_req_o: 1 cycle.
  - Total stall for a zero-wait bus (ack on first BUSY cycle) is 2 cycles (IDLE, BUSY). DONE is the release cycle.
- bus_ack_i outside BUSY: ignored.

Test Plan:
1. Read word, ack 3 cycles after req.
   - Stimulus: mem_ce_i=1, we=0, addr=0x0000_1006, sel=4'b0011; bus_rdata_i=0xDEAD_BEEF with ack.
   - Required: bus_addr_o=0x0000_1004, bus_sel_o=4'b0011, bus_req_o high for 3 cycles, stallreq_o high through BUSY.
   - Required in DONE: mem_data_o=0xDEAD_BEEF, stallreq_o=0.
2. Write, zero-wait bus.
   - Stimulus: we=1, addr=0x20, data=0x1234_5678, sel=4'b1111; ack on first BUSY cycle.
   - Required: bus_we_o=1, bus_wdata_o=0x1234_5678, total stall 2 cycles, mem_data_o=0 outside DONE.
3. Timeout with TIMEOUT=4 and no ack.
   - Required: bus_req_o high exactly 4 cycles, bus_err_o single pulse, DONE with mem_data_o=0, then IDLE.
   - Repeat with ack arriving on the same cycle as the timeout: bus_err_o=0 and data is captured.
4. Flush in BUSY on a write.
   - Stimulus: flush_i pulsed in BUSY; ack 2 cycles later.
   - Required: write completes on bus; stallreq_o stays high through the DONE cycle; mem_data_o=0; FSM returns to IDLE with the aborted flag cleared.
5. Flush coinciding with mem_ce_i in IDLE.
   - Required: bus_req_o stays 0, stallreq_o=0.
6. Reset mid-BUSY, then back-to-back reads.
   - Stimulus: assert rst during BUSY; deassert; then issue two reads with a stray ack arriving after reset.
   - Required: all outputs 0 the cycle after rst; stray ack ignored.
   - Required: back-to-back reads each pass through IDLE→BUSY→DONE, with bus_req_o low for at least 2 cycles between them.
